alu_seq_exec: RTL and testbench

- Execution-side responder for the 4-bit ALU operation code produced by the ALU control decoder.
- Accepts two 32-bit operands plus an operation code through a valid/ready handshake, and computes the result.
- Shifts are iterative, one bit per cycle, to save area.
- Holds the result until the downstream stage accepts it.
- Sits between the operand/ALU-control stage and writeback in the multi-cycle datapath variant.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_seq_shifter.sv | 47 ++++
 rtl/alu_seq_exec.sv | 143 ++++++++++++++
 tb/tb_alu_seq_exec.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 4-bit operation codes driven by the ALU control
// decoder and the state encoding of the sequential execution unit.
// The optional ALU_SEQ_BARREL_SHIFT_EN build switch is handled in alu_seq_exec.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_ORI = 4'b1000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_seq_shifter.sv
// Iterative one-bit-per-cycle shifter used by alu_seq_exec when the barrel
// shifter build (ALU_SEQ_BARREL_SHIFT_EN) is not selected.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   start_i       : load data_i/shamt_i/dir_left_i into the working state
//   dir_left_i    : 1 = shift left (SLL), 0 = logical shift right (SRL)
//   data_i        : value to shift
//   shamt_i       : number of single-bit steps
//   result_o      : working register
//   done_o        : remaining count is zero
module alu_seq_shifter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   dir_left_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   done_o
);

  logic [DATA_WIDTH-1:0]  work_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   dir_left_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q     <= '0;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
    end else if (start_i) begin
      work_q     <= data_i;
      cnt_q      <= shamt_i;
      dir_left_q <= dir_left_i;
    end else if (cnt_q != '0) begin
      work_q <= dir_left_q ? {work_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, work_q[DATA_WIDTH-1:1]};
      cnt_q  <= cnt_q - SHAMT_WIDTH'(1);
    end
  end

  assign result_o = work_q;
  assign done_o   = (cnt_q == '0);

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU execution unit with valid/ready handshakes on both sides.
// Non-shift ops complete one cycle after accept; SLL/SRL shift one bit per
// cycle unless ALU_SEQ_BARREL_SHIFT_EN is defined, in which case they are
// computed combinationally at accept like every other op.
// Ports:
//   clk, reset                 : clock and synchronous active-high reset
//   in_valid_i / in_ready_o    : operand handshake
//   alu_operation_i, a_i, b_i  : op code and operands, sampled on accept
//   out_valid_o / out_ready_i  : result handshake
//   result_o, illegal_op_o     : result and undefined-op flag, held until taken
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  illegal_op_o
);

  alu_state_e            state_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  illegal_q;

  logic                  accept;
  logic                  is_shift;
  logic [DATA_WIDTH-1:0] imm_result;
  logic                  imm_illegal;
  logic [SHAMT_WIDTH-1:0] shamt;

  assign accept   = in_valid_i & in_ready_q;
  assign shamt    = b_i[SHAMT_WIDTH-1:0];
  assign is_shift = (alu_operation_i == ALU_SLL) || (alu_operation_i == ALU_SRL);

  always_comb begin
    imm_result  = '0;
    imm_illegal = 1'b0;
    case (alu_operation_i)
      ALU_ADD:         imm_result = a_i + b_i;
      ALU_SUB:         imm_result = a_i - b_i;
      ALU_XOR:         imm_result = a_i ^ b_i;
      ALU_OR, ALU_ORI: imm_result = a_i | b_i;
      ALU_AND:         imm_result = a_i & b_i;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
      ALU_SLL:         imm_result = a_i << shamt;
      ALU_SRL:         imm_result = a_i >> shamt;
`else
      // Result comes from the iterative shifter instead.
      ALU_SLL, ALU_SRL: imm_result = '0;
`endif
      ALU_LUI:         imm_result = b_i;
      default:         imm_illegal = 1'b1;
    endcase
  end

`ifndef ALU_SEQ_BARREL_SHIFT_EN
  logic [DATA_WIDTH-1:0] sh_result;
  logic                  sh_done;

  alu_seq_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .start_i   (accept & is_shift),
    .dir_left_i(alu_operation_i == ALU_SLL),
    .data_i    (a_i),
    .shamt_i   (shamt),
    .result_o  (sh_result),
    .done_o    (sh_done)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
            if (is_shift) begin
              state_q <= SHIFT;
            end else
`endif
            begin
              result_q    <= imm_result;
              illegal_q   <= imm_illegal;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
        SHIFT: begin
          if (sh_done) begin
            result_q    <= sh_result;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
`endif
        DONE: begin
          // No accept in this cycle: in_ready_o rises only after the handshake.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign result_o     = result_q;
  assign illegal_op_o = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed scoreboard bench for alu_seq_exec.
module tb_alu_seq_exec;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        illegal_op_o;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq_exec #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .alu_operation_i(alu_operation_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .result_o       (result_o),
    .illegal_op_o   (illegal_op_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: shifts done bit by bit, subtraction as two's complement add.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    e.res = 32'h0;
    e.ill = 1'b0;
    e.lat = 1;
    case (op)
      4'h0: e.res = a + b;
      4'h1: e.res = a + (~b) + 32'h1;
      4'h2: e.res = a ^ b;
      4'h3, 4'h8: e.res = a | b;
      4'h4: e.res = a & b;
      4'h5, 4'h7: begin
        e.res = a;
        for (int i = 0; i < int'(b[4:0]); i++)
          e.res = (op == 4'h5) ? {e.res[30:0], 1'b0} : {1'b0, e.res[31:1]};
`ifndef ALU_SEQ_BARREL_SHIFT_EN
        e.lat = int'(b[4:0]) + 2;
`endif
      end
      4'h9: e.res = b;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    check($sformatf("in_ready_before op%h", op), 32'(in_ready_o), 32'h1);
    in_valid_i      = 1'b1;
    alu_operation_i = op;
    a_i             = a;
    b_i             = b;
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the result must not depend on them.
    in_valid_i      = 1'b0;
    a_i             = $urandom;
    b_i             = $urandom;
    alu_operation_i = 4'h4;
    lat = 1;
    while (!out_valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    check($sformatf("latency op%h", op), 32'(lat), 32'(e.lat));
    check($sformatf("result op%h", op), result_o, e.res);
    check($sformatf("illegal op%h", op), 32'(illegal_op_o), 32'(e.ill));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid_i = 1'b1;
      a_i        = $urandom;
      b_i        = $urandom;
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      check("hold result", result_o, e.res);
      check("hold out_valid", 32'(out_valid_o), 32'h1);
      check("hold in_ready", 32'(in_ready_o), 32'h0);
    end
    @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    check($sformatf("post_hs out_valid op%h", op), 32'(out_valid_o), 32'h0);
    check($sformatf("post_hs in_ready op%h", op), 32'(in_ready_o), 32'h1);
  endtask

  initial begin
    reset           = 1'b1;
    in_valid_i      = 1'b0;
    out_ready_i     = 1'b0;
    alu_operation_i = 4'h0;
    a_i             = 32'h0;
    b_i             = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready_o), 32'h1);
    check("rst out_valid", 32'(out_valid_o), 32'h0);
    check("rst result", result_o, 32'h0);
    check("rst illegal", 32'(illegal_op_o), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(4'h1, 32'h0000_0005, 32'h0000_0007, 0);
    run_op(4'h8, 32'h0000_00F0, 32'h0000_000F, 0);
    run_op(4'h5, 32'h0000_0001, 32'h0000_001F, 0);
    run_op(4'h7, 32'hDEAD_BEEF, 32'h0000_0000, 0);
    run_op(4'h0, 32'h1234_0000, 32'h0000_5678, 5);
    run_op(4'hC, 32'hAAAA_AAAA, 32'h5555_5555, 0);
    run_op(4'h9, 32'hFFFF_FFFF, 32'h1234_5000, 0);
    run_op(4'h2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_op(4'h4, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op(4'h3, 32'h8000_0000, 32'h0000_0001, 0);
    run_op(4'h7, 32'h8000_0000, 32'hFFFF_FFE4, 0);
    run_op(4'h5, 32'hC000_0003, 32'h0000_0003, 2);
    run_op(4'h6, 32'h1, 32'h1, 0);
    run_op(4'hF, 32'h1, 32'h1, 0);

    // Reset in the middle of a 10-step shift.
    @(negedge clk);
    in_valid_i      = 1'b1;
    alu_operation_i = 4'h5;
    a_i             = 32'h3;
    b_i             = 32'd10;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst out_valid", 32'(out_valid_o), 32'h0);
    check("midrst in_ready", 32'(in_ready_o), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("aborted no out_valid", 32'(out_valid_o), 32'h0);
    run_op(4'h0, 32'h0000_0010, 32'h0000_0020, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
